// File: rtl/mlp_pkg.sv
// Shared types and constants for the mlp front-end sequencer.
package mlp_pkg;

  localparam int unsigned MLP_NCH  = 6;
  localparam int unsigned MLP_NOUT = 3;

  typedef logic [7:0] sample_t;
  typedef sample_t [MLP_NCH-1:0]  frame_t;
  typedef sample_t [MLP_NOUT-1:0] score_t;

  typedef enum logic [1:0] {EMPTY, SETTLE, RESULT} seq_state_e;

  // Unsigned subtract that floors at zero instead of wrapping.
  function automatic sample_t sat_sub(sample_t a, sample_t b);
    return (a > b) ? sample_t'(a - b) : '0;
  endfunction

endpackage

// File: rtl/baseline_sub.sv
// Per-channel baseline register file and saturating baseline subtraction.
module baseline_sub
  import mlp_pkg::*;
#(
  parameter int unsigned NCH  = 6,
  parameter int unsigned IdxW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_we_i,
  input  logic [2:0]      cfg_ch_i,
  input  logic [7:0]      cfg_data_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [7:0]      sample_i,
  output logic [7:0]      cond_o
);

  logic [NCH-1:0][7:0] base_q, base_d;

  always_comb begin
    base_d = base_q;
    if (cfg_we_i && (32'(cfg_ch_i) < NCH)) begin
      base_d[cfg_ch_i] = cfg_data_i;
    end
  end

  // Reads the registered value, so a same-cycle write only affects later samples.
  always_comb begin
    cond_o = sat_sub(sample_i, base_q[idx_i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/mlp_frame_sequencer.sv
// Assembles conditioned sample frames, holds them on the MLP inputs for a settle
// time, then captures the scores and offers them on a valid/ready handshake.
module mlp_frame_sequencer #(
  parameter int unsigned NCH    = 6,
  parameter int unsigned NOUT   = 3,
  parameter int unsigned SETTLE = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [7:0]          s_data_i,
  input  logic                s_last_i,
  input  logic                cfg_we_i,
  input  logic [2:0]          cfg_ch_i,
  input  logic [7:0]          cfg_data_i,
  output logic [8*NCH-1:0]    mlp_din_o,
  input  logic [8*NOUT-1:0]   mlp_dout_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [8*NOUT-1:0]   res_data_o,
  output logic                err_o,
  output logic [7:0]          err_cnt_o
);
  import mlp_pkg::*;

  localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCH - 1);
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE - 1);

  seq_state_e          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NCH-1:0][7:0] asm_q, asm_d;
  logic [NCH-1:0][7:0] din_q, din_d;
  logic [8*NOUT-1:0]   res_q, res_d;
  logic                res_valid_q, res_valid_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [7:0] cond;
  logic       last_slot, hold_free, accept, frame_done, frame_err;

  baseline_sub #(
    .NCH  (NCH),
    .IdxW (IdxW)
  ) u_baseline (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_data_i (cfg_data_i),
    .idx_i      (idx_q),
    .sample_i   (s_data_i),
    .cond_o     (cond)
  );

  // Hold side can take a frame when empty or when its result leaves this cycle.
  always_comb begin
    last_slot  = (idx_q == LastIdx);
    hold_free  = (state_q == mlp_pkg::EMPTY) ||
                 ((state_q == mlp_pkg::RESULT) && res_ready_i);
    s_ready_o  = !(last_slot && !hold_free);
    accept     = s_valid_i && s_ready_o;
    frame_done = accept && last_slot && s_last_i;
    frame_err  = accept && (s_last_i != last_slot);
  end

  always_comb begin
    asm_d     = asm_q;
    din_d     = din_q;
    idx_d     = idx_q;
    err_d     = frame_err;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      asm_d[idx_q] = cond;
      idx_d        = (frame_done || frame_err) ? '0 : idx_q + 1'b1;
    end
    // The last sample bypasses the assembly slot so the frame lands one cycle after it.
    if (frame_done) begin
      din_d          = asm_q;
      din_d[LastIdx] = cond;
    end
    if (frame_err && (err_cnt_q != 8'hff)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      mlp_pkg::EMPTY: begin
        if (frame_done) begin
          state_d = mlp_pkg::SETTLE;
          cnt_d   = CntInit;
        end
      end
      mlp_pkg::SETTLE: begin
        if (cnt_q == '0) begin
          res_d       = mlp_dout_i;
          res_valid_d = 1'b1;
          state_d     = mlp_pkg::RESULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      mlp_pkg::RESULT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          if (frame_done) begin
            state_d = mlp_pkg::SETTLE;
            cnt_d   = CntInit;
          end else begin
            state_d = mlp_pkg::EMPTY;
          end
        end
      end
      default: begin
        state_d     = mlp_pkg::EMPTY;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= mlp_pkg::EMPTY;
      idx_q       <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      din_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      din_q       <= din_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mlp_din_o   = din_q;
  assign res_data_o  = res_q;
  assign res_valid_o = res_valid_q;
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: doc/mlp_frame_sequencer.md
# mlp_frame_sequencer

Front-end and capture stage for the olfactory `mlp` classifier. It accepts a serial stream of 8-bit sensor samples and subtracts a per-channel baseline. It assembles 6-channel feature frames and holds each frame stable on the MLP inputs for a programmable settle time. It then registers the 3 MLP scores and offers them downstream on a valid/ready handshake.

## Interface
Parameters:
- `NCH`, 6, channels per frame; equals the MLP input width.
- `NOUT`, 3, MLP output count.
- `SETTLE`, 4, cycles the held frame is stable before the scores are captured; must be ≥1.

Ports:
- `clk_i`  in  1  sole clock. One clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `s_valid_i`  in  1  sample valid.
- `s_ready_o`  out  1  sample accepted when `s_valid_i && s_ready_o`.
- `s_data_i`  in  8  raw unsigned sample.
- `s_last_i`  in  1  marks channel NCH-1 of a frame.
- `cfg_we_i`  in  1  baseline write strobe.
- `cfg_ch_i`  in  3  baseline channel index; writes with index ≥NCH are ignored.
- `cfg_data_i`  in  8  baseline value.
- `mlp_din_o`  out  8×NCH  held frame driven to MLP `din`.
- `mlp_dout_i`  in  8×NOUT  MLP `dout`, which is combinational from `mlp_din_o`.
- `res_valid_o`  out  1  scores valid.
- `res_ready_i`  in  1  scores consumed when `res_valid_o && res_ready_i`.
- `res_data_o`  out  8×NOUT  registered scores.
- `err_o`  out  1  one-cycle framing-error pulse.
- `err_cnt_o`  out  8  saturating framing-error count.

## Operation
Assembly side:
- Channel counter `idx` runs 0..NCH-1; each accepted sample is written to assembly slot `idx`.
- Conditioning per sample: `max(s_data_i - baseline[idx], 0)`, unsigned 8-bit with floor saturation at 0.
- Frame complete: the accepted sample has `idx==NCH-1` and `s_last_i==1`. On completion `idx←0`.
  - If the hold side is EMPTY, or is releasing in this same cycle, the assembled frame is copied into the hold register.
- Framing error, either case:
  - `s_last_i==1` with `idx<NCH-1`.
  - `s_last_i==0` with `idx==NCH-1`.
  - Response: the sample is consumed, the partial frame is discarded, `idx←0`, `err_o` pulses, and `err_cnt_o` increments, saturating at 255.
- `s_ready_o` is 1 except when `idx==NCH-1` and the hold side cannot take a frame this cycle. The stall therefore falls only on the last sample.
- A baseline write takes effect for samples accepted in later cycles. A write in the same cycle as a sample uses the old baseline.

Hold/capture FSM, states EMPTY, SETTLE, RESULT:
- EMPTY → SETTLE on frame transfer; settle counter `cnt←SETTLE-1`.
- SETTLE: `cnt` decrements each cycle. At `cnt==0`, `res_data_o←mlp_dout_i` and the FSM moves to RESULT.
- RESULT: `res_valid_o=1`. On handshake, it goes to SETTLE if a completed frame is transferring in that cycle, otherwise to EMPTY.
- `mlp_din_o` changes only on a frame transfer, and never while in SETTLE or RESULT. The scores captured therefore always belong to the held frame.

Reset:
- `idx=0`, FSM=EMPTY, `cnt=0`.
- `mlp_din_o` all 0; `res_data_o` all 0; `res_valid_o=0`.
- `err_o=0`; `err_cnt_o=0`; `s_ready_o=1` from the first cycle after reset.
- Baselines reset to 0.
- Reset mid-frame or mid-result discards everything in flight without emitting a result.

## Timing
- Sample-to-slot latency: 1 cycle (registered).
- Last-sample acceptance to `mlp_din_o` update: 1 cycle.
- `mlp_din_o` update to `res_valid_o` high: SETTLE cycles.
- Back-to-back throughput: one frame per max(NCH, SETTLE+1) cycles when `res_ready_i` is held high.
- `res_data_o` stays stable while `res_valid_o && !res_ready_i`.
- `err_o` is registered and asserts the cycle after the offending sample.

## Structure
- Shared package `mlp_pkg` holds:
  - Constants `MLP_NCH=6`, `MLP_NOUT=3`.
  - Typedef `sample_t` (8-bit unsigned).
  - Typedef `frame_t` (`sample_t [MLP_NCH]`).
  - Typedef `score_t` (`sample_t [MLP_NOUT]`).
  - Enum `seq_state_e {EMPTY, SETTLE, RESULT}`.
- One natural sub-module, `baseline_sub`: the baseline register file plus the saturating subtract, indexed by `idx`.
- The top holds the assembly counter, the hold/capture FSM and the error counter.

## Test plan
- Baselines all 0, samples 10,20,30,40,50,60 with last on 60, `res_ready_i=1`:
  - `mlp_din_o={10,20,30,40,50,60}` one cycle after the last sample.
  - `res_valid_o` rises SETTLE cycles later; `res_data_o` equals the MLP output.
- Baseline ch2=50, sample ch2=30 → slot 2 = 0. Baseline ch3=5, sample 40 → slot 3 = 35.
- `s_last_i` on the 4th sample:
  - `err_o` pulses once and `err_cnt_o=1`; no result is produced.
  - The next clean frame is assembled from `idx=0`.
- Hold `res_ready_i=0` after the first result and stream a second frame:
  - `s_ready_o` drops only on that frame's 6th sample.
  - `res_data_o` is unchanged.
  - Raising `res_ready_i` transfers the frame the same cycle and enters SETTLE.
- Assert `rst_i` mid-SETTLE:
  - Next cycle: `res_valid_o=0`, `mlp_din_o=0`, `err_cnt_o=0`, `s_ready_o=1`.
- 300 consecutive framing errors → `err_cnt_o` saturates at 255.
